// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with hold/+4/absolute/relative updates and
// call/return support through a circular return-address stack.
module pc_unit_ras #(
  parameter int unsigned    W        = 64,
  parameter int unsigned    DEPTH    = 8,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [2:0]   PS,
  input  logic [W-1:0] in,
  input  logic         stall,
  output logic [W-1:0] PC,
  output logic [W-1:0] PC4,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_overflow,
  output logic         ras_underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  pc_q;
  logic [W-1:0]  stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [CW-1:0] count;
  logic          ovf_q;
  logic          unf_q;

  logic [W-1:0]  off;
  logic [W-1:0]  rel;
  logic [W-1:0]  pc_next;
  logic          do_push;
  logic          do_pop;
  logic          set_unf;

  assign PC            = pc_q;
  assign PC4           = pc_q + W'(4);
  assign off           = {in[W-3:0], 2'b00};
  assign rel           = PC4 + off;
  assign ptr_inc       = ptr + PW'(1);
  assign ras_empty     = (count == '0);
  assign ras_full      = (count == FULL_CNT);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  always_comb begin
    pc_next = pc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_unf = 1'b0;
    case (PS)
      3'b000: pc_next = pc_q;
      3'b001, 3'b111: pc_next = PC4;
      3'b010: pc_next = in;
      3'b011: pc_next = rel;
      3'b100: begin
        do_push = 1'b1;
        pc_next = in;
      end
      3'b101: begin
        do_push = 1'b1;
        pc_next = rel;
      end
      3'b110: begin
        // A return with nothing stacked falls through rather than jumping to stale data.
        if (ras_empty) begin
          set_unf = 1'b1;
          pc_next = PC4;
        end else begin
          do_pop  = 1'b1;
          pc_next = stack[ptr];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ptr   <= '0;
      count <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!stall) begin
      pc_q <= pc_next;
      if (do_push) begin
        ptr <= ptr_inc;
        // When full the write lands on the oldest slot, so depth stays saturated.
        if (ras_full) ovf_q <= 1'b1;
        else          count <= count + CW'(1);
      end
      if (do_pop) begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
      if (set_unf) unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !stall && do_push) stack[ptr_inc] <= PC4;
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_unit_ras;

  localparam int unsigned   W        = 64;
  localparam int unsigned   DEPTH    = 8;
  localparam logic [63:0]   RST_PC   = 64'h100;

  logic         clock;
  logic         reset;
  logic [2:0]   PS;
  logic [63:0]  din;
  logic         stall;
  logic [63:0]  PC;
  logic [63:0]  PC4;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_overflow;
  logic         ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  logic        m_ovf;
  logic        m_unf;

  pc_unit_ras #(.W(W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .PS           (PS),
    .in           (din),
    .stall        (stall),
    .PC           (PC),
    .PC4          (PC4),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_push(input logic [63:0] v);
    if (m_q.size() == DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
    m_q.push_back(v);
  endtask

  // Drive one cycle, advance the model, then settle just past the edge.
  task automatic step(input logic r, input logic s, input logic [2:0] ps, input logic [63:0] d);
    logic [63:0] nxt4;
    logic [63:0] tgt;
    reset = r; stall = s; PS = ps; din = d;
    @(posedge clock);
    nxt4 = m_pc + 64'd4;
    tgt  = nxt4 + (d << 2);
    if (r) begin
      m_pc = RST_PC;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!s) begin
      case (ps)
        3'd0: m_pc = m_pc;
        3'd1, 3'd7: m_pc = nxt4;
        3'd2: m_pc = d;
        3'd3: m_pc = tgt;
        3'd4: begin model_push(nxt4); m_pc = d; end
        3'd5: begin model_push(nxt4); m_pc = tgt; end
        3'd6: begin
          if (m_q.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = nxt4;
          end else begin
            m_pc = m_q.pop_back();
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 64'd0);
    step(1'b0, 1'b1, 3'd0, 64'd0);
    n_checks++;
    if (PC !== 64'h100) begin n_errors++; $display("FAIL reset_pc: got %h want %h", PC, 64'h100); end
    n_checks++;
    if (PC4 !== 64'h104) begin n_errors++; $display("FAIL reset_pc4: got %h want %h", PC4, 64'h104); end
    n_checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      n_errors++; $display("FAIL reset_flags: got %b want 1000", {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
  endtask

  task automatic test_increment();
    logic [63:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 3'd1, 64'd0);
      exp_pc = 64'h100 + 64'(4 * i);
      n_checks++;
      if (PC !== exp_pc) begin n_errors++; $display("FAIL inc_pc[%0d]: got %h want %h", i, PC, exp_pc); end
      n_checks++;
      if (PC4 !== exp_pc + 64'd4) begin n_errors++; $display("FAIL inc_pc4[%0d]: got %h want %h", i, PC4, exp_pc + 64'd4); end
    end
  endtask

  task automatic test_branch_rel();
    step(1'b0, 1'b0, 3'd2, 64'h200);
    step(1'b0, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    n_checks++;
    if (PC !== 64'h200) begin n_errors++; $display("FAIL rel_stall: got %h want %h", PC, 64'h200); end
    step(1'b0, 1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    n_checks++;
    if (PC !== 64'h1F8) begin n_errors++; $display("FAIL rel_branch: got %h want %h", PC, 64'h1F8); end
    step(1'b0, 1'b0, 3'd7, 64'h0);
    n_checks++;
    if (PC !== 64'h1FC) begin n_errors++; $display("FAIL reserved_ps: got %h want %h", PC, 64'h1FC); end
  endtask

  task automatic test_call_return();
    step(1'b0, 1'b0, 3'd2, 64'h1000);
    step(1'b0, 1'b0, 3'd4, 64'h4000);
    n_checks++;
    if (PC !== 64'h4000 || ras_empty !== 1'b0) begin
      n_errors++; $display("FAIL call_abs: got pc=%h empty=%b want pc=4000 empty=0", PC, ras_empty);
    end
    step(1'b0, 1'b0, 3'd6, 64'h0);
    n_checks++;
    if (PC !== 64'h1004 || ras_empty !== 1'b1) begin
      n_errors++; $display("FAIL return: got pc=%h empty=%b want pc=1004 empty=1", PC, ras_empty);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] site;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 3'd2, 64'h10000 + 64'(i * 'h100));
      step(1'b0, 1'b0, 3'd4, 64'h80000);
      if (i == 6) begin
        n_checks++;
        if (ras_full !== 1'b0) begin n_errors++; $display("FAIL full_early: got %b want 0", ras_full); end
      end
      if (i == 7) begin
        n_checks++;
        if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin
          n_errors++; $display("FAIL full_at_8: got full=%b ovf=%b want 1 0", ras_full, ras_overflow);
        end
      end
    end
    n_checks++;
    if (ras_overflow !== 1'b1 || ras_full !== 1'b1) begin
      n_errors++; $display("FAIL overflow_9: got ovf=%b full=%b want 1 1", ras_overflow, ras_full);
    end
    for (int k = 8; k >= 1; k--) begin
      step(1'b0, 1'b0, 3'd6, 64'h0);
      site = 64'h10000 + 64'(k * 'h100) + 64'd4;
      n_checks++;
      if (PC !== site) begin n_errors++; $display("FAIL lifo_pop[%0d]: got %h want %h", k, PC, site); end
    end
    n_checks++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      n_errors++; $display("FAIL drained: got empty=%b full=%b want 1 0", ras_empty, ras_full);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 3'd2, 64'h300);
    step(1'b0, 1'b0, 3'd6, 64'h0);
    n_checks++;
    if (PC !== 64'h304 || ras_underflow !== 1'b1) begin
      n_errors++; $display("FAIL underflow: got pc=%h unf=%b want 304 1", PC, ras_underflow);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd1, 64'h0);
    step(1'b0, 1'b0, 3'd4, 64'h500);
    step(1'b0, 1'b0, 3'd6, 64'h0);
    n_checks++;
    if (ras_underflow !== 1'b1 || ras_overflow !== 1'b1 || PC !== 64'h314) begin
      n_errors++; $display("FAIL sticky: got unf=%b ovf=%b pc=%h want 1 1 314", ras_underflow, ras_overflow, PC);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC);
    n_checks++;
    if (PC4 !== 64'h0) begin n_errors++; $display("FAIL wrap_pc4: got %h want 0", PC4); end
    step(1'b0, 1'b0, 3'd1, 64'h0);
    n_checks++;
    if (PC !== 64'h0) begin n_errors++; $display("FAIL wrap_pc: got %h want 0", PC); end
  endtask

  task automatic test_reset_mid_call();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 3'd5, 64'(i + 1));
    step(1'b1, 1'b1, 3'd4, 64'h9000);
    n_checks++;
    if (PC !== 64'h100 || {ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      n_errors++; $display("FAIL reset_mid_call: got pc=%h flags=%b want 100 1000",
                           PC, {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
  endtask

  task automatic test_random();
    logic [2:0]  ps;
    logic [63:0] d;
    logic        r;
    logic        s;
    int          sel;
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      ps  = (sel >= 8) ? 3'd6 : 3'(sel);
      d   = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($signed(32'($urandom_range(0, 64)) - 32));
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 99) == 0);
      step(r, s, ps, d);
      n_checks++;
      if (PC !== m_pc) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, PC, m_pc); end
      n_checks++;
      if (PC4 !== m_pc + 64'd4) begin n_errors++; $display("FAIL rnd_pc4[%0d]: got %h want %h", i, PC4, m_pc + 64'd4); end
      n_checks++;
      if (ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == DEPTH)) begin
        n_errors++; $display("FAIL rnd_level[%0d]: got empty=%b full=%b want size %0d", i, ras_empty, ras_full, m_q.size());
      end
      n_checks++;
      if (ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
        n_errors++; $display("FAIL rnd_flags[%0d]: got ovf=%b unf=%b want %b %b", i, ras_overflow, ras_underflow, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; PS = 3'd0; din = 64'd0;
    m_pc = RST_PC; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_increment();
    test_branch_rel();
    test_call_return();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid_call();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
